// File: rtl/pkt_rx.sv
// pkt_rx: network receive engine; pairs half-word BODY flits into words
// and writes them into data memory. Define PKT_RX_PORTCHK_EN to filter HEADs by MY_PORT.
module pkt_rx #(
    parameter logic [1:0]    pu_num     = 2'd0,
    parameter int            WIDTH      = 31,
    parameter int            FLOWBL     = 16,
    parameter int            PORT       = 1,
    parameter int            DMSB       = 7,
    parameter logic [PORT:0] MY_PORT    = '0,
    parameter int            FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLOWBL+1:0] rx,
    input  logic              arm,
    input  logic [DMSB:0]     base,
    input  logic [DMSB+1:0]   limit,
    output logic              wr_req,
    output logic [DMSB:0]     wr_ad,
    output logic [WIDTH:0]    wr_d,
    input  logic              wr_gnt,
    output logic              busy,
    output logic              done,
    output logic [3:0]        err,
    output logic [DMSB+1:0]   rcount
);

    localparam int FLOWBH = FLOWBL + 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];

    localparam logic [1:0] T_HEAD = 2'd1;
    localparam logic [1:0] T_BODY = 2'd2;
    localparam logic [1:0] T_TAIL = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_RECV,
        S_DROP,
        S_DRAIN
    } state_t;

    state_t state, state_nx;

    logic [1:0]        typ;
    logic [FLOWBL-1:0] pay;
    logic              is_head, is_body, is_tail;
    logic              port_ok;

    logic [FLOWBL-1:0] low_r;
    logic              half_r;
    logic [DMSB:0]     ptr_r;
    logic [DMSB+1:0]   lim_r;

    logic [WIDTH:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]     rd_p, wr_p;
    logic [AW:0]       cnt, cnt_nx;

    logic              arm_load;
    logic              store_low, push_try, odd_tail, stray, clr_half;
    logic              lim_hit, full, pop, push_ok, set_ovf, set_lim;
    logic [FLOWBL-1:0] hi_half;
    logic [WIDTH:0]    push_data;

    logic              unused_ok;

    assign typ     = rx[FLOWBH:FLOWBL];
    assign pay     = rx[FLOWBL-1:0];
    assign is_head = (typ == T_HEAD);
    assign is_body = (typ == T_BODY);
    assign is_tail = (typ == T_TAIL);

`ifdef PKT_RX_PORTCHK_EN
    assign port_ok = (pay[PORT:0] == MY_PORT);
`else
    assign port_ok = 1'b1;
`endif

    assign unused_ok = ^{pu_num, MY_PORT};

    // FIFO status and push qualification; limit check wins over overflow
    always_comb begin
        full      = (cnt == FULL_CNT);
        pop       = wr_req & wr_gnt;
        lim_hit   = (rcount == lim_r);
        push_ok   = push_try & ~lim_hit & (~full | pop);
        set_lim   = push_try & lim_hit;
        set_ovf   = push_try & ~lim_hit & full & ~pop;
        hi_half   = odd_tail ? '0 : pay;
        push_data = {hi_half, low_r};
        cnt_nx    = cnt + (AW+1)'(push_ok) - (AW+1)'(pop);
        arm_load  = (state == S_IDLE) & arm;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (arm) state_nx = S_ARMED;
            S_ARMED: if (is_head) state_nx = port_ok ? S_RECV : S_DROP;
            S_DROP:  if (is_tail) state_nx = S_ARMED;
            S_RECV:  if (is_tail) state_nx = S_DRAIN;
            S_DRAIN: if (cnt_nx == '0) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Per-state flit actions
    always_comb begin
        store_low = 1'b0;
        push_try  = 1'b0;
        odd_tail  = 1'b0;
        stray     = 1'b0;
        clr_half  = 1'b0;
        busy      = (state != S_IDLE);
        unique case (state)
            S_ARMED: stray = is_body | is_tail;
            S_RECV: begin
                unique case (1'b1)
                    is_body: begin
                        store_low = ~half_r;
                        push_try  = half_r;
                    end
                    is_tail: begin
                        push_try = half_r;
                        odd_tail = half_r;
                        clr_half = 1'b1;
                    end
                    is_head: begin
                        stray    = 1'b1;
                        clr_half = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // Assembly, address pointer, count and sticky status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            low_r  <= '0;
            half_r <= 1'b0;
            ptr_r  <= '0;
            lim_r  <= '0;
            rcount <= '0;
            err    <= '0;
            done   <= 1'b0;
        end else begin
            done <= (state == S_DRAIN) && (cnt_nx == '0);
            if (arm_load) begin
                ptr_r  <= base;
                lim_r  <= limit;
                rcount <= '0;
                err    <= '0;
                half_r <= 1'b0;
            end else begin
                if (pop) ptr_r <= ptr_r + 1'b1;
                if (push_ok) rcount <= rcount + 1'b1;
                if (store_low) begin
                    low_r  <= pay;
                    half_r <= 1'b1;
                end else if (push_try | clr_half) begin
                    half_r <= 1'b0;
                end
                err <= err | {set_lim, odd_tail, set_ovf, stray};
            end
        end
    end

    // Write buffer pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_p <= '0;
            wr_p <= '0;
            cnt  <= '0;
        end else begin
            if (push_ok) wr_p <= wr_p + 1'b1;
            if (pop) rd_p <= rd_p + 1'b1;
            cnt <= cnt_nx;
        end
    end

    // Write buffer storage; contents are don't-care while empty
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_p] <= push_data;
    end

    // Write port
    always_comb begin
        wr_req = (cnt != '0);
        wr_ad  = ptr_r;
        wr_d   = wr_req ? mem[rd_p] : '0;
    end

endmodule

// File: tb/tb_pkt_rx.sv
// tb_pkt_rx: table vectors, hand-written corner sequences and
// randomized packets against a packet-level reference model.
module tb_pkt_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] rx;
    logic        arm;
    logic [7:0]  base;
    logic [8:0]  limit;
    logic        wr_req;
    logic [7:0]  wr_ad;
    logic [31:0] wr_d;
    logic        wr_gnt;
    logic        busy;
    logic        done;
    logic [3:0]  err;
    logic [8:0]  rcount;

    localparam logic [1:0] IDL = 2'd0;
    localparam logic [1:0] HD  = 2'd1;
    localparam logic [1:0] BD  = 2'd2;
    localparam logic [1:0] TL  = 2'd3;

    pkt_rx #(
        .pu_num(2'd1), .WIDTH(31), .FLOWBL(16), .PORT(1),
        .DMSB(7), .MY_PORT(2'd2), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .rx(rx), .arm(arm),
        .base(base), .limit(limit), .wr_req(wr_req),
        .wr_ad(wr_ad), .wr_d(wr_d), .wr_gnt(wr_gnt),
        .busy(busy), .done(done), .err(err), .rcount(rcount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        logic [7:0]  base;
        logic [8:0]  lim;
        int          nh;
        logic [15:0] h [4];
        int          nw;
        logic [7:0]  ea [2];
        logic [31:0] ed [2];
        logic [3:0]  eerr;
        logic [8:0]  erc;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;
    bit   rand_gnt = 1'b0;
    wr_t  got [$];
    wr_t  exp_q [$];
    logic [15:0] pre [$];
    logic [15:0] post [$];
    logic [31:0] words [$];
    vec_t tv [6];

    always @(negedge clk) begin
        if (wr_req && wr_gnt) got.push_back('{wr_ad, wr_d});
        if (done) done_cnt++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        if (rand_gnt) wr_gnt = ($urandom_range(0, 3) != 0);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] t, input logic [15:0] p);
        rx = {t, p};
        tick();
        rx = '0;
    endtask

    task automatic gap();
        int n;
        n = $urandom_range(0, 2);
        for (int i = 0; i < n; i++) send(IDL, 16'($urandom));
    endtask

    task automatic do_arm(input logic [7:0] b, input logic [8:0] l);
        base  = b;
        limit = l;
        arm   = 1'b1;
        tick();
        arm   = 1'b0;
        got.delete();
        done_cnt = 0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        chk({nm, "_drain_timeout"}, 32'(busy), 32'd0);
        chk({nm, "_done_at_busy_fall"}, 32'(done), 32'd1);
        tick();
    endtask

    task automatic cmp_writes(input string nm);
        chk({nm, "_nwrites"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            chk($sformatf("%s_ad%0d", nm, i), 32'(got[i].a), 32'(exp_q[i].a));
            chk($sformatf("%s_d%0d", nm, i), got[i].d, exp_q[i].d);
        end
        chk({nm, "_done_pulses"}, 32'(done_cnt), 32'd1);
    endtask

    initial begin
        rst    = 1'b1;
        rx     = '0;
        arm    = 1'b0;
        base   = '0;
        limit  = '0;
        wr_gnt = 1'b0;

        tv[0] = '{8'h10, 9'd8, 2, '{16'h1234, 16'hABCD, 16'h0, 16'h0}, 1,
                  '{8'h10, 8'h00}, '{32'hABCD1234, 32'h0}, 4'h0, 9'd1};
        tv[1] = '{8'h20, 9'd8, 1, '{16'h00AA, 16'h0, 16'h0, 16'h0}, 1,
                  '{8'h20, 8'h00}, '{32'h000000AA, 32'h0}, 4'h4, 9'd1};
        tv[2] = '{8'hFF, 9'd8, 4, '{16'h1111, 16'h2222, 16'h3333, 16'h4444}, 2,
                  '{8'hFF, 8'h00}, '{32'h22221111, 32'h44443333}, 4'h0, 9'd2};
        tv[3] = '{8'h40, 9'd1, 4, '{16'h0001, 16'h0002, 16'h0003, 16'h0004}, 1,
                  '{8'h40, 8'h00}, '{32'h00020001, 32'h0}, 4'h8, 9'd1};
        tv[4] = '{8'h50, 9'd0, 2, '{16'h0005, 16'h0006, 16'h0, 16'h0}, 0,
                  '{8'h00, 8'h00}, '{32'h0, 32'h0}, 4'h8, 9'd0};
        tv[5] = '{8'h60, 9'd2, 3, '{16'h0007, 16'h0008, 16'h0009, 16'h0}, 2,
                  '{8'h60, 8'h61}, '{32'h00080007, 32'h00000009}, 4'h4, 9'd2};

        // reset values
        tick();
        tick();
        chk("rst_wr_req", 32'(wr_req), 32'd0);
        chk("rst_wr_ad", 32'(wr_ad), 32'd0);
        chk("rst_wr_d", wr_d, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rcount", 32'(rcount), 32'd0);
        rst = 1'b0;
        tick();

        // table vectors: single packets to port 2, grant always on
        wr_gnt = 1'b1;
        for (int v = 0; v < 6; v++) begin
            string nm;
            nm = $sformatf("vec%0d", v);
            do_arm(tv[v].base, tv[v].lim);
            send(HD, 16'h0002);
            for (int i = 0; i < tv[v].nh; i++) send(BD, tv[v].h[i]);
            send(TL, 16'h0);
            wait_idle(nm);
            exp_q.delete();
            for (int i = 0; i < tv[v].nw; i++)
                exp_q.push_back('{tv[v].ea[i], tv[v].ed[i]});
            cmp_writes(nm);
            chk({nm, "_err"}, 32'(err), 32'(tv[v].eerr));
            chk({nm, "_rcount"}, 32'(rcount), 32'(tv[v].erc));
        end

        // overflow with grant held off, then drain
        wr_gnt = 1'b0;
        do_arm(8'h70, 9'd8);
        send(HD, 16'h0002);
        send(BD, 16'd0);
        chk("ovf_wr_req_half", 32'(wr_req), 32'd0);
        send(BD, 16'd1);
        chk("ovf_wr_req_latency", 32'(wr_req), 32'd1);
        for (int i = 2; i < 12; i++) send(BD, 16'(i));
        chk("ovf_err", 32'(err), 32'h2);
        chk("ovf_rcount", 32'(rcount), 32'd4);
        send(TL, 16'h0);
        chk("ovf_busy_drain", 32'(busy), 32'd1);
        wr_gnt = 1'b1;
        wait_idle("ovf");
        exp_q.delete();
        for (int k = 0; k < 4; k++)
            exp_q.push_back('{8'(8'h70 + k), {16'(2*k+1), 16'(2*k)}});
        cmp_writes("ovf");

        // push into a full buffer coincident with a pop
        wr_gnt = 1'b0;
        do_arm(8'h80, 9'd8);
        send(HD, 16'h0002);
        for (int i = 0; i < 9; i++) send(BD, 16'(i));
        wr_gnt = 1'b1;
        send(BD, 16'd9);
        chk("fullpop_err", 32'(err), 32'h0);
        chk("fullpop_rcount", 32'(rcount), 32'd5);
        send(TL, 16'h0);
        wait_idle("fullpop");
        exp_q.delete();
        for (int k = 0; k < 5; k++)
            exp_q.push_back('{8'(8'h80 + k), {16'(2*k+1), 16'(2*k)}});
        cmp_writes("fullpop");

        // stray flits before HEAD
        do_arm(8'hA0, 9'd8);
        send(BD, 16'h5555);
        chk("stray_err", 32'(err), 32'h1);
        chk("stray_busy", 32'(busy), 32'd1);
        send(TL, 16'h0);
        send(HD, 16'h0002);
        send(TL, 16'h0);
        wait_idle("stray");
        exp_q.delete();
        cmp_writes("stray");
        chk("stray_err_end", 32'(err), 32'h1);

        // packet to another port
        do_arm(8'h30, 9'd8);
        send(HD, 16'h0001);
        for (int i = 0; i < 4; i++) send(BD, 16'(16'h0100 + i));
        send(TL, 16'h0);
        exp_q.delete();
`ifdef PKT_RX_PORTCHK_EN
        chk("drop_busy", 32'(busy), 32'd1);
        chk("drop_nowrite", 32'(got.size()), 32'd0);
        send(HD, 16'h0002);
        send(BD, 16'h0001);
        send(BD, 16'h0002);
        send(TL, 16'h0);
        wait_idle("drop");
        exp_q.push_back('{8'h30, 32'h00020001});
        cmp_writes("drop");
        chk("drop_rcount", 32'(rcount), 32'd1);
`else
        wait_idle("noport");
        exp_q.push_back('{8'h30, 32'h01010100});
        exp_q.push_back('{8'h31, 32'h01030102});
        cmp_writes("noport");
        chk("noport_rcount", 32'(rcount), 32'd2);
`endif
        chk("port_err", 32'(err), 32'h0);

        // reset in the middle of a packet
        wr_gnt = 1'b0;
        do_arm(8'h90, 9'd8);
        send(HD, 16'h0002);
        send(HD, 16'h0002);
        send(BD, 16'h0001);
        send(BD, 16'h0002);
        chk("mid_pre_req", 32'(wr_req), 32'd1);
        chk("mid_pre_err", 32'(err), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_req", 32'(wr_req), 32'd0);
        chk("mid_rst_ad", 32'(wr_ad), 32'd0);
        chk("mid_rst_d", wr_d, 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_rcount", 32'(rcount), 32'd0);
        tick();
        rst = 1'b0;
        wr_gnt = 1'b1;
        got.delete();
        send(BD, 16'h0003);
        send(BD, 16'h0004);
        send(TL, 16'h0);
        tick();
        tick();
        chk("mid_after_writes", 32'(got.size()), 32'd0);
        chk("mid_after_busy", 32'(busy), 32'd0);

        // randomized packets against the reference model
        rand_gnt = 1'b1;
        for (int it = 0; it < 40; it++) begin
            logic [7:0] b;
            logic [8:0] l;
            bit         stray, mid, odd;
            int         k, m, nw, np;
            string      nm;
            nm = $sformatf("rnd%0d", it);
            b = 8'($urandom);
            l = 9'($urandom_range(0, 4));
            do_arm(b, l);
            pre.delete();
            post.delete();
            words.delete();
            stray = ($urandom_range(0, 3) == 0);
            if (stray) begin
                send(BD, 16'($urandom));
                gap();
            end
`ifdef PKT_RX_PORTCHK_EN
            if ($urandom_range(0, 2) == 0) begin
                logic [1:0] p;
                logic [15:0] hv;
                p = 2'($urandom_range(0, 2));
                if (p == 2'd2) p = 2'd3;
                hv = 16'($urandom);
                send(HD, {hv[15:2], p});
                np = $urandom_range(0, 3);
                for (int i = 0; i < np; i++) send(BD, 16'($urandom));
                send(TL, 16'($urandom));
                gap();
            end
`endif
            begin
                logic [15:0] hv;
                hv = 16'($urandom);
                send(HD, {hv[15:2], 2'b10});
            end
            gap();
            mid = ($urandom_range(0, 3) == 0);
            k = 0;
            if (mid) begin
                k = $urandom_range(0, 3);
                for (int i = 0; i < k; i++) begin
                    pre.push_back(16'($urandom));
                    send(BD, pre[i]);
                    gap();
                end
                send(HD, 16'h0002);
                gap();
            end
            m = $urandom_range(0, 9);
            for (int i = 0; i < m; i++) begin
                post.push_back(16'($urandom));
                send(BD, post[i]);
                gap();
            end
            send(TL, 16'($urandom));
            wait_idle(nm);

            for (int i = 0; i + 1 < pre.size(); i += 2)
                words.push_back({pre[i+1], pre[i]});
            for (int i = 0; i + 1 < post.size(); i += 2)
                words.push_back({post[i+1], post[i]});
            odd = (post.size() % 2) == 1;
            if (odd) words.push_back({16'h0, post[post.size()-1]});
            nw = words.size();
            exp_q.delete();
            for (int i = 0; i < nw && i < int'(l); i++)
                exp_q.push_back('{8'(b + 8'(i)), words[i]});
            cmp_writes(nm);
            chk({nm, "_err"}, 32'(err),
                32'({nw > int'(l), odd, 1'b0, stray | mid}));
            chk({nm, "_rcount"}, 32'(rcount), 32'(exp_q.size()));
        end
        rand_gnt = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
